// File: rtl/key_cond_pkg.sv
// Shared constants and types for the push-button conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_cond_pkg;

   // Production timing at 50 MHz: 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period
   localparam int unsigned DEF_NUM_KEYS        = 3;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

   // Board wiring of the three buttons onto the key bus
   localparam int unsigned KEY_IDX_RESET = 0;
   localparam int unsigned KEY_IDX_LOAD  = 1;
   localparam int unsigned KEY_IDX_START = 2;

   // Auto-repeat phase of a held key
   typedef enum logic [1:0] {
      REP_IDLE   = 2'd0,
      REP_DELAY  = 2'd1,
      REP_PERIOD = 2'd2
   } rep_state_e;

endpackage

// File: rtl/key_debounce_lane.sv
// One button lane: 2-flop synchroniser, debounce counter, press/release edge pulses (+ auto-repeat with KEY_AUTOREPEAT_EN).
// Latency: raw edge to registered level/pulse is 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
module key_debounce_lane
   import key_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic core_clk,
   input  logic arst_n,
   input  logic key_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject timing values the counters cannot represent
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("key_debounce_lane: illegal timing parameters");
   end

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             state_q, state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             sample_held;
   logic             flip;
   logic             rep_fire;

   // Synchronise, count disagreement with the accepted level, flip after a full stable run
   always_comb begin
      sync1_d     = key_n;
      sync2_d     = sync1_q;
      sample_held = ~sync2_q;
      flip        = (sample_held != state_q) && (cnt_q == CNT_LAST);
      cnt_d       = '0;
      if ((sample_held != state_q) && !flip) begin
         cnt_d = cnt_q + 1'b1;
      end
      state_d   = flip ? sample_held : state_q;
      press_d   = (flip && sample_held) || rep_fire;
      release_d = flip && !sample_held;
   end

   // Lane state; synchroniser resets to the released level so a held key debounces normally
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         state_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned       HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned       HOLD_W      = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   rep_state_e        rep_q, rep_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   // Hold timer: starts at an accepted press, cleared by release; a repeat never lands on a release cycle
   always_comb begin
      rep_d    = rep_q;
      hold_d   = hold_q;
      rep_fire = 1'b0;
      if (flip && sample_held) begin
         rep_d  = REP_DELAY;
         hold_d = '0;
      end else if (flip || !state_q) begin
         rep_d  = REP_IDLE;
         hold_d = '0;
      end else begin
         case (rep_q)
            REP_DELAY: begin
               if (hold_q == DELAY_LAST) begin
                  rep_fire = 1'b1;
                  rep_d    = REP_PERIOD;
                  hold_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            REP_PERIOD: begin
               if (hold_q == PERIOD_LAST) begin
                  rep_fire = 1'b1;
                  hold_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            default: begin
               rep_d  = REP_IDLE;
               hold_d = '0;
            end
         endcase
      end
   end

   // Repeat phase and hold timer registers
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         rep_q  <= REP_IDLE;
         hold_q <= '0;
      end else begin
         rep_q  <= rep_d;
         hold_q <= hold_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign pressed       = state_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions active-low raw buttons into debounced active-high levels and press/release pulses; KEY_AUTOREPEAT_EN adds hold auto-repeat.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw edge to registered outputs; all outputs are flop-driven.
// Backpressure: none; consumer must take pulses in the cycle they are high.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                core_clk,
   input  logic                arst_n,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);

   // Lanes are fully independent apart from clock and reset
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
      key_debounce_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_lane (
         .core_clk      (core_clk),
         .arst_n        (arst_n),
         .key_n         (key[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule
